gol_step_engine: RTL

- Initiator side of the gol_ram port. Advances the Game of Life grid held in gol_ram by exactly one generation per start request.
- Sweeps every cell on a toroidal grid, reads the 3x3 neighbourhood, computes the next state and writes it back.
- Bit plane layout per 4-bit word: bit0 = current generation, bit1 = next generation, bits[3:2] = owner-defined; the engine preserves them.
- Sits between the top-level frame/step controller and gol_ram, and owns the RAM port while busy.

---
 rtl/gol_step_engine.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gol_step_engine.sv
// gol_step_engine: advances the toroidal Game of Life grid held in gol_ram
// by one generation per start; bit0 = current, bit1 = next, bits[3:2] kept.
module gol_step_engine #(
    parameter int W_LOG2 = 8,
    parameter int H_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [3:0]  ram_din,
    input  logic [3:0]  ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        CALC_RD,
        CALC_WAIT,
        CALC_WR,
        COMMIT_RD,
        COMMIT_WAIT,
        COMMIT_WR,
        DONE
    } state_t;

    state_t            state;
    logic [W_LOG2-1:0] x;
    logic [H_LOG2-1:0] y;
    logic [3:0]        k;
    logic [3:0]        nb;
    logic [3:0]        ctr;

    logic [1:0]        kx;
    logic [1:0]        ky;
    logic [W_LOG2-1:0] nx;
    logic [H_LOG2-1:0] ny;
    logic [W_LOG2-1:0] x_inc;
    logic [H_LOG2-1:0] y_inc;
    logic [3:0]        n;
    logic              nxt;
    logic              last;

    always_comb begin
        ky = 2'd0;
        kx = 2'd0;
        unique case (1'b1)
            (k < 4'd3): begin
                ky = 2'd0;
                kx = 2'(k);
            end
            (k >= 4'd3 && k < 4'd6): begin
                ky = 2'd1;
                kx = 2'(k - 4'd3);
            end
            (k >= 4'd6): begin
                ky = 2'd2;
                kx = 2'(k - 4'd6);
            end
        endcase
    end

    // neighbour coordinates wrap naturally in the address-width arithmetic
    assign nx    = x + W_LOG2'(kx) - W_LOG2'(1);
    assign ny    = y + H_LOG2'(ky) - H_LOG2'(1);
    assign x_inc = x + W_LOG2'(1);
    assign y_inc = (&x) ? y + H_LOG2'(1) : y;
    assign last  = (&x) & (&y);
    assign n     = nb + {3'b000, ram_dout[0]};
    assign nxt   = (n == 4'd3) | (ctr[0] & (n == 4'd2));

    // outputs are registered from the current state, so read data for
    // the address issued in state k arrives while in state k+2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            k         <= '0;
            nb        <= '0;
            ctr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_din   <= '0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC_RD;
                        x     <= '0;
                        y     <= '0;
                        k     <= '0;
                        nb    <= '0;
                    end
                end
                CALC_RD: begin
                    busy     <= 1'b1;
                    ram_addr <= 16'({ny, nx});
                    if (k == 4'd6) begin
                        ctr <= ram_dout;
                    end else if (k >= 4'd2) begin
                        nb <= n;
                    end
                    if (k == 4'd8) begin
                        state <= CALC_WAIT;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                CALC_WAIT: begin
                    nb    <= n;
                    state <= CALC_WR;
                end
                CALC_WR: begin
                    ram_addr <= 16'({y, x});
                    ram_we   <= 1'b1;
                    ram_din  <= {ctr[3:2], nxt, ctr[0]};
                    nb       <= '0;
                    k        <= '0;
                    x        <= x_inc;
                    y        <= y_inc;
                    state    <= last ? COMMIT_RD : CALC_RD;
                end
                COMMIT_RD: begin
                    ram_addr <= 16'({y, x});
                    state    <= COMMIT_WAIT;
                end
                COMMIT_WAIT: begin
                    state <= COMMIT_WR;
                end
                COMMIT_WR: begin
                    ram_we  <= 1'b1;
                    ram_din <= {ram_dout[3:2], ram_dout[1], ram_dout[1]};
                    x       <= x_inc;
                    y       <= y_inc;
                    state   <= last ? DONE : COMMIT_RD;
                end
                DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    gen_count <= gen_count + 16'd1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
